// File: rtl/stack_unit_if.sv
// ============================================================================
// stack_unit_if : CPU <-> data-stack request/response bundle
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface stack_unit_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
);
  logic              i_valid;
  logic [2:0]        i_op;
  logic [WIDTH-1:0]  i_data;
  logic              o_ready;
  logic [WIDTH-1:0]  o_top;
  logic [WIDTH-1:0]  o_next;
  logic [ADDR_W:0]   o_depth;
  logic              o_empty;
  logic              o_full;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_valid, i_op, i_data,
    input  o_ready, o_top, o_next, o_depth, o_empty, o_full, o_overflow, o_underflow
  );

  modport slave (
    input  i_valid, i_op, i_data,
    output o_ready, o_top, o_next, o_depth, o_empty, o_full, o_overflow, o_underflow
  );
endinterface

`default_nettype wire

// File: rtl/stack_unit.sv
// ============================================================================
// stack_unit : data stack with T/N registers and a downward-growing spill RAM
// Revision   : 1.0
// ============================================================================
`default_nettype none

module stack_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  wire logic      i_clock,
  input  wire logic      i_reset_n,
  stack_unit_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH + 2);
  localparam logic [ADDR_W:0] CNT_ZERO   = '0;
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_TWO    = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W:0] CNT_THREE  = (ADDR_W + 1)'(3);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPLACE = 3'b011;
  localparam logic [2:0] OP_SET     = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_DUP     = 3'b110;
  localparam logic [2:0] OP_RSVD    = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  t_q, t_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic [ADDR_W:0]   c_q, c_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  // DEPTH is a power of two, so DEPTH+1-c and DEPTH+2-c reduce to 1-c and 2-c mod DEPTH.
  assign w_wr_addr = ADDR_W'(1) - c_q[ADDR_W-1:0];
  assign w_rd_addr = ADDR_W'(2) - c_q[ADDR_W-1:0];

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    n_d      = n_q;
    c_d      = c_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = w_wr_addr;

    if (state_q == ST_REFILL) begin
      n_d     = rd_data_q;
      state_d = ST_IDLE;
    end else if (bus.i_valid) begin
      case (bus.i_op)
        OP_PUSH, OP_DUP: begin
          if (c_q == FULL_COUNT) begin
            ovf_d = 1'b1;
          end else if (bus.i_op == OP_DUP && c_q == CNT_ZERO) begin
            unf_d = 1'b1;
          end else begin
            ram_we = (c_q >= CNT_TWO);
            n_d    = t_q;
            t_d    = (bus.i_op == OP_DUP) ? t_q : bus.i_data;
            c_d    = c_q + CNT_ONE;
          end
        end
        OP_POP, OP_REPLACE: begin
          if ((bus.i_op == OP_POP && c_q == CNT_ZERO) ||
              (bus.i_op == OP_REPLACE && c_q < CNT_TWO)) begin
            unf_d = 1'b1;
          end else begin
            t_d = (bus.i_op == OP_POP) ? n_q : bus.i_data;
            c_d = c_q - CNT_ONE;
            if (c_q >= CNT_THREE) begin
              ram_re   = 1'b1;
              ram_addr = w_rd_addr;
              state_d  = ST_REFILL;
            end else begin
              n_d = '0;
            end
          end
        end
        OP_SET: begin
          if (c_q == CNT_ZERO) unf_d = 1'b1;
          else                 t_d   = bus.i_data;
        end
        OP_SWAP: begin
          if (c_q < CNT_TWO) begin
            unf_d = 1'b1;
          end else begin
            t_d = n_q;
            n_d = t_q;
          end
        end
        OP_NOP, OP_RSVD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      n_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Backing store keeps its contents across reset; only the count is cleared.
  always_ff @(posedge i_clock) begin
    if (ram_we) mem[ram_addr] <= n_q;
    if (ram_re) rd_data_q <= mem[ram_addr];
  end

  assign bus.o_ready     = (state_q == ST_IDLE);
  assign bus.o_top       = t_q;
  assign bus.o_next      = n_q;
  assign bus.o_depth     = c_q;
  assign bus.o_empty     = (c_q == CNT_ZERO);
  assign bus.o_full      = (c_q == FULL_COUNT);
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_unit.sv
// ============================================================================
// tb_stack_unit : directed scoreboard bench for stack_unit (ADDR_W=2)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_stack_unit;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 2;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] REPL = 3'd3;
  localparam logic [2:0] SET  = 3'd4;
  localparam logic [2:0] SWAP = 3'd5;
  localparam logic [2:0] DUP  = 3'd6;
  localparam logic [2:0] RSVD = 3'd7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  stack_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  typedef struct {
    int          due;
    string       name;
    logic [15:0] t;
    logic [15:0] n;
    bit          chk_n;
    int          d;
    bit          rdy;
    bit          ovf;
    bit          unf;
  } exp_s;

  exp_s sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, req, cyc);
    end
  endfunction

  function automatic void check_state(input exp_s e);
    chk({e.name, ".top"},   32'(bus.o_top),   32'(e.t));
    if (e.chk_n) chk({e.name, ".next"}, 32'(bus.o_next), 32'(e.n));
    chk({e.name, ".depth"}, 32'(bus.o_depth), 32'(e.d));
    chk({e.name, ".ready"}, 32'(bus.o_ready), 32'(e.rdy));
    chk({e.name, ".empty"}, 32'(bus.o_empty), 32'(e.d == 0));
    chk({e.name, ".full"},  32'(bus.o_full),  32'(e.d == 6));
    chk({e.name, ".ovf"},   32'(bus.o_overflow),  32'(e.ovf));
    chk({e.name, ".unf"},   32'(bus.o_underflow), 32'(e.unf));
  endfunction

  // Monitor: compares each expected snapshot on the falling edge of the cycle it is due.
  always @(negedge clk) begin : mon
    exp_s e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_state(e);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] data, input string nm,
                       input logic [15:0] et, input logic [15:0] en, input int ed,
                       input bit eovf, input bit eunf, input bit refill, input bit skip2,
                       output int acc);
    exp_s e;
    int   guard;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_data  = data;
    guard = 0;
    while (!bus.o_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.o_ready) begin
      total++;
      bad++;
      $display("FAIL %s.accept got ready=0 expected ready=1 within 8 cycles", nm);
      bus.i_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    acc     = cyc;
    e.due   = acc;
    e.name  = nm;
    e.t     = et;
    e.n     = en;
    e.chk_n = !refill;
    e.d     = ed;
    e.rdy   = !refill;
    e.ovf   = eovf;
    e.unf   = eunf;
    sb.push_back(e);
    if (refill && !skip2) begin
      e.due   = acc + 1;
      e.name  = {nm, ".refill"};
      e.chk_n = 1'b1;
      e.rdy   = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic op1(input logic [2:0] op, input logic [15:0] data, input string nm,
                     input logic [15:0] et, input logic [15:0] en, input int ed,
                     input bit eovf, input bit eunf, input bit refill);
    int a;
    issue(op, data, nm, et, en, ed, eovf, eunf, refill, 1'b0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic exp_s reset_exp(input string nm);
    exp_s e;
    e.due = 0; e.name = nm; e.t = 16'h0; e.n = 16'h0; e.chk_n = 1'b1;
    e.d = 0; e.rdy = 1'b1; e.ovf = 1'b0; e.unf = 1'b0;
    return e;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a1, a2;
    bus.i_valid = 1'b0;
    bus.i_op    = NOP;
    bus.i_data  = '0;

    // A: basic push/pop/replace/dup and refill latency
    do_reset();
    #1 check_state(reset_exp("reset_a"));
    op1(PUSH, 16'h0001, "a_push1", 16'h0001, 16'h0000, 1, 0, 0, 0);
    op1(PUSH, 16'h0002, "a_push2", 16'h0002, 16'h0001, 2, 0, 0, 0);
    op1(PUSH, 16'h0003, "a_push3", 16'h0003, 16'h0002, 3, 0, 0, 0);
    op1(NOP,  16'hFFFF, "a_nop",   16'h0003, 16'h0002, 3, 0, 0, 0);
    op1(RSVD, 16'hFFFF, "a_rsvd",  16'h0003, 16'h0002, 3, 0, 0, 0);
    op1(POP,  16'h0000, "a_pop",   16'h0002, 16'h0001, 2, 0, 0, 1);
    op1(PUSH, 16'h0003, "a_repush",16'h0003, 16'h0002, 3, 0, 0, 0);
    op1(REPL, 16'h0005, "a_repl",  16'h0005, 16'h0001, 2, 0, 0, 1);
    op1(DUP,  16'h0000, "a_dup",   16'h0005, 16'h0005, 3, 0, 0, 0);
    op1(POP,  16'h0000, "a_pop2",  16'h0005, 16'h0001, 2, 0, 0, 1);
    op1(POP,  16'h0000, "a_pop3",  16'h0001, 16'h0000, 1, 0, 0, 0);
    op1(POP,  16'h0000, "a_pop4",  16'h0000, 16'h0000, 0, 0, 0, 0);
    op1(SET,  16'h0009, "a_set0",  16'h0000, 16'h0000, 0, 0, 1, 0);
    op1(DUP,  16'h0000, "a_dup0",  16'h0000, 16'h0000, 0, 0, 1, 0);

    // B: fill to capacity, overflow, swap, drain through every RAM slot
    do_reset();
    #1 check_state(reset_exp("reset_b"));
    op1(PUSH, 16'h0001, "b_push1", 16'h0001, 16'h0000, 1, 0, 0, 0);
    op1(PUSH, 16'h0002, "b_push2", 16'h0002, 16'h0001, 2, 0, 0, 0);
    op1(PUSH, 16'h0003, "b_push3", 16'h0003, 16'h0002, 3, 0, 0, 0);
    op1(PUSH, 16'h0004, "b_push4", 16'h0004, 16'h0003, 4, 0, 0, 0);
    op1(PUSH, 16'h0005, "b_push5", 16'h0005, 16'h0004, 5, 0, 0, 0);
    op1(PUSH, 16'h0006, "b_push6", 16'h0006, 16'h0005, 6, 0, 0, 0);
    op1(PUSH, 16'h0007, "b_push7", 16'h0006, 16'h0005, 6, 1, 0, 0);
    op1(SWAP, 16'h0000, "b_swap",  16'h0005, 16'h0006, 6, 1, 0, 0);
    op1(DUP,  16'h0000, "b_dupf",  16'h0005, 16'h0006, 6, 1, 0, 0);
    issue(POP, 16'h0, "b_pop6", 16'h0006, 16'h0004, 5, 1, 0, 1, 0, a1);
    issue(POP, 16'h0, "b_pop5", 16'h0004, 16'h0003, 4, 1, 0, 1, 0, a2);
    chk("b_b2b_gap1", 32'(a2 - a1), 32'd2);
    issue(POP, 16'h0, "b_pop4", 16'h0003, 16'h0002, 3, 1, 0, 1, 0, a1);
    chk("b_b2b_gap2", 32'(a1 - a2), 32'd2);
    op1(POP,  16'h0000, "b_pop3",  16'h0002, 16'h0001, 2, 1, 0, 1);
    op1(POP,  16'h0000, "b_pop2",  16'h0001, 16'h0000, 1, 1, 0, 0);

    // C: asynchronous reset in the middle of a refill
    do_reset();
    op1(POP,  16'h0000, "c_pop0",  16'h0000, 16'h0000, 0, 0, 1, 0);
    op1(PUSH, 16'h0001, "c_push1", 16'h0001, 16'h0000, 1, 0, 1, 0);
    op1(PUSH, 16'h0002, "c_push2", 16'h0002, 16'h0001, 2, 0, 1, 0);
    op1(PUSH, 16'h0003, "c_push3", 16'h0003, 16'h0002, 3, 0, 1, 0);
    issue(POP, 16'h0, "c_pop", 16'h0002, 16'h0000, 2, 0, 1, 1, 1, a1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_state(reset_exp("c_async_reset"));
    @(negedge clk);
    rst_n = 1'b1;
    op1(PUSH, 16'h00AA, "c_pushaa", 16'h00AA, 16'h0000, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
